hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the execute stage. Generates PC/IF-ID stall,
//  ID-EX bubble and IF-ID/ID-EX flush controls for three events:
//  - load-use hazards
//  - taken branches resolved in EX
//  - multi-cycle MDU ops (mul/div) occupying EX

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle MDU occupancy with start/done handshake, timeout watchdog and stall counter.
module hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 34,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             ex_mdu_i,
  input  logic             mdu_done_i,
  input  logic             branch_taken_i,
  output logic             mdu_start_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned BusyW = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic [0:0] {StRun, StMduBusy} state_e;

  state_e           state_q, state_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             mdu_release;

  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  // EX result advances either on a real done or when the watchdog expires.
  assign mdu_release = mdu_done_i || (busy_cnt_q == BusyW'(MDU_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      busy_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      err_q      <= err_d;
      if (pc_stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StRun: begin
        if (!branch_taken_i && ex_mdu_i) begin
          state_d    = StMduBusy;
          busy_cnt_d = BusyW'(1);
        end
      end
      StMduBusy: begin
        if (mdu_release) begin
          state_d    = StRun;
          busy_cnt_d = '0;
          if (!mdu_done_i) begin
            err_d = 1'b1;
          end
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = StRun;
        busy_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mdu_start_o    = 1'b0;
    pc_stall_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    idex_stall_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
          end else if (ex_mdu_i) begin
            mdu_start_o    = 1'b1;
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_bubble_o = 1'b1;
          end else if (load_use) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end
        end
        StMduBusy: begin
          if (!mdu_release) begin
            pc_stall_o     = 1'b1;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_bubble_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q == StMduBusy);
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int unsigned TO     = 8;
  localparam int unsigned CW     = 4;
  localparam int          SatMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          use1, use2, memread, mdu, done, br;
  logic          start, pc_st, ifid_st, idex_st, idex_bub, exmem_bub, ifid_fl, idex_fl;
  logic          busy, err;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       m_busy;
  int       m_n;
  bit       m_err;
  int       m_stalls;
  logic [7:0] e_ctl;

  hazard_ctrl #(
    .MDU_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (use1),
    .id_use_rs2_i  (use2),
    .ex_rd_i       (ex_rd),
    .ex_memread_i  (memread),
    .ex_mdu_i      (mdu),
    .mdu_done_i    (done),
    .branch_taken_i(br),
    .mdu_start_o   (start),
    .pc_stall_o    (pc_st),
    .ifid_stall_o  (ifid_st),
    .idex_stall_o  (idex_st),
    .idex_bubble_o (idex_bub),
    .exmem_bubble_o(exmem_bub),
    .ifid_flush_o  (ifid_fl),
    .idex_flush_o  (idex_fl),
    .busy_o        (busy),
    .err_o         (err),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected controls {start,pc,ifid,idex,idex_bub,exmem_bub,ifid_fl,idex_fl}
  function automatic logic [7:0] exp_ctl();
    logic lu;
    lu = memread && (ex_rd != 5'd0) &&
         ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
    if (rst) return 8'h00;
    if (!m_busy) begin
      if (br)  return 8'b0000_0011;
      if (mdu) return 8'b1111_0100;
      if (lu)  return 8'b0110_1000;
      return 8'h00;
    end
    if (done || m_n == TO) return 8'h00;
    return 8'b0111_0100;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_err = 0; m_stalls = 0;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic md, input logic dn, input logic b);
    id_rs1 = rs1; id_rs2 = rs2; use1 = u1; use2 = u2; ex_rd = rd;
    memread = mr; mdu = md; done = dn; br = b;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, then advances model.
  task automatic tick(input string tag);
    #3;
    e_ctl = exp_ctl();
    chk({tag, ".ctl"}, {24'd0, start, pc_st, ifid_st, idex_st, idex_bub, exmem_bub,
                        ifid_fl, idex_fl}, {24'd0, e_ctl});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, ".cnt"}, {28'd0, stall_cnt}, m_stalls);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (e_ctl[6]) m_stalls = (m_stalls >= SatMax) ? SatMax : m_stalls + 1;
      if (!m_busy) begin
        if (!br && mdu) begin m_busy = 1; m_n = 1; end
      end else if (done) begin
        m_busy = 0; m_n = 0;
      end else if (m_n == TO) begin
        m_busy = 0; m_n = 0; m_err = 1;
      end else begin
        m_n++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    tick("reset");
    rst = 1'b0;

    // Load-use on rs1, then same with rd=x0
    set_in(5, 0, 1, 0, 5, 1, 0, 0, 0); tick("lu");
    chk("lu.cnt1", {28'd0, stall_cnt}, 32'd1);
    set_in(0, 0, 1, 0, 0, 1, 0, 0, 0); tick("lu_x0");
    set_in(0, 7, 0, 1, 7, 1, 0, 0, 0); tick("lu_rs2");
    set_in(0, 7, 0, 0, 7, 1, 0, 0, 0); tick("lu_nouse");

    // MDU op with done on the third busy cycle
    rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("rst2");
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("mdu_t0");
    tick("mdu_t1");
    tick("mdu_t2");
    done = 1'b1; tick("mdu_t3");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("mdu_t4");
    chk("mdu.cnt3", {28'd0, stall_cnt}, 32'd3);
    chk("mdu.run", {31'd0, busy}, 32'd0);

    // Branch wins over MDU and load-use
    set_in(3, 0, 1, 0, 3, 1, 1, 0, 1); tick("br_prio");
    chk("br.run", {31'd0, busy}, 32'd0);

    // Timeout: no done for TO busy cycles
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); tick("to_issue");
    for (int i = 1; i <= TO; i++) tick($sformatf("to_busy%0d", i));
    mdu = 1'b0; tick("to_after");
    chk("to.err", {31'd0, err}, 32'd1);
    mdu = 1'b1; tick("to2_issue");
    mdu = 1'b0; tick("to2_b1");
    done = 1'b1; tick("to2_b2");
    done = 1'b0; tick("to2_after");
    chk("to.sticky", {31'd0, err}, 32'd1);

    // Reset while busy_cnt=3
    mdu = 1'b1; tick("rm_issue");
    mdu = 1'b0; tick("rm_b1");
    tick("rm_b2");
    rst = 1'b1; tick("rm_rst");
    rst = 1'b0; tick("rm_after");
    chk("rm.busy", {31'd0, busy}, 32'd0);
    chk("rm.err", {31'd0, err}, 32'd0);

    // Saturation: 20 load-use stall cycles
    rst = 1'b1; tick("sat_rst");
    rst = 1'b0;
    set_in(9, 0, 1, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick("sat");
    chk("sat.max", {28'd0, stall_cnt}, 32'd15);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("sat_hold");

    // Random traffic
    rst = 1'b1; tick("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
